// File: rtl/cfifo_sink_pkg.sv
// -----------------------------------------------------------------------------
// cfifo_sink_pkg
// Shared definitions for the clocked drive/free sink:
//   sink_state_e : acceptance FSM states (IDLE, ACCEPT, STALL)
//   cnt_w()      : width of an occupancy counter able to hold 0..depth
//   MIN_SYNC     : smallest legal depth of an i_drive synchronizer chain
// -----------------------------------------------------------------------------
package cfifo_sink_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        STALL  = 2'd2
    } sink_state_e;

    localparam int MIN_SYNC = 2;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/cfifo_sync_sink_sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
// Reset-to-0 flop chain that brings a two-phase request line (i_drive) into
// the clk domain. Usable by any clocked drive/free endpoint.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   d        : asynchronous input level
//   q        : synchronized level, STAGES cycles later
// Parameters:
//   STAGES   : chain depth; values below MIN_SYNC are raised to MIN_SYNC
// -----------------------------------------------------------------------------
module sync_chain
    import cfifo_sink_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    localparam int N = (STAGES < MIN_SYNC) ? MIN_SYNC : STAGES;

    logic [N-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[N-2:0], d};
        end
    end

    assign q = ff[N-1];

endmodule

// File: rtl/cfifo_sync_sink.sv
// -----------------------------------------------------------------------------
// cfifo_sync_sink
// Clocked terminating end of a two-phase drive/free micro-pipeline. Each
// i_drive transition is one token carrying bundled i_data. The word is
// captured into a small synchronous FIFO and acknowledged with one o_free
// transition. The FIFO head is presented show-ahead on a valid/ready port.
//
// Ports:
//   clk, rst    : system clock, asynchronous active-high reset
//   i_drive     : two-phase token request (either edge = one token)
//   i_data      : bundled data, stable until the matching o_free transition
//   o_free      : two-phase acknowledge, one transition per accepted token
//   o_valid     : FIFO head holds a word
//   o_data      : FIFO head word
//   i_ready     : consumer takes the head word when o_valid=1
//   o_count     : current FIFO occupancy
// Optional (macro CFIFO_SINK_STATS_EN):
//   i_stats_clr : synchronous clear of the stall counter (wins over increment)
//   o_stall_cnt : saturating count of cycles spent in STALL
//
// Handshake rules:
//   consumer side : a word transfers on every rising clk edge where
//                   o_valid=1 and i_ready=1; o_valid/o_data never depend
//                   combinationally on i_ready.
//   producer side : one token in flight; i_drive may toggle again only
//                   after o_free has toggled for the previous token.
// -----------------------------------------------------------------------------
module cfifo_sync_sink
    import cfifo_sink_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_drive,
    input  logic [DATA_W-1:0]         i_data,
    output logic                      o_free,
    output logic                      o_valid,
    output logic [DATA_W-1:0]         o_data,
    input  logic                      i_ready,
    output logic [cnt_w(DEPTH)-1:0]   o_count
`ifdef CFIFO_SINK_STATS_EN
    ,
    input  logic                      i_stats_clr,
    output logic [15:0]               o_stall_cnt
`endif
);

    localparam int CW = cnt_w(DEPTH);
    localparam int AW = $clog2(DEPTH);

    // ------------------------------------------------------------------
    // Token detection
    // ------------------------------------------------------------------
    logic drv_sync;
    logic drv_seen;
    logic tok;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (i_drive),
        .q   (drv_sync)
    );

    // drv_seen tracks the i_drive level already acknowledged, so any
    // difference from the synchronized level is a fresh token.
    assign tok = drv_sync ^ drv_seen;

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     rd_ptr_p1;
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] head_q;
    logic              free_q;
    logic              pop;
    logic              push;
    logic              push_ok;

    assign rd_ptr_p1 = rd_ptr + AW'(1);
    assign o_valid   = (count != '0);
    assign pop       = o_valid & i_ready;
    // A pop in the same cycle frees the slot the push needs, so a full
    // FIFO can still accept.
    assign push_ok   = (count < CW'(DEPTH)) | pop;

    // ------------------------------------------------------------------
    // Acceptance FSM
    // ------------------------------------------------------------------
    sink_state_e state;
    sink_state_e state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        case (state)
            IDLE: begin
                if (tok) begin
                    state_nxt = ACCEPT;
                end
            end
            ACCEPT, STALL: begin
                if (push_ok) begin
                    push      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = STALL;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            head_q   <= '0;
            free_q   <= 1'b0;
            drv_seen <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + AW'(1);
                free_q   <= ~free_q;
                drv_seen <= ~drv_seen;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // Head register: after a pop the next word is either already
            // in memory, or (when the FIFO held one word) is the word being
            // pushed this same cycle. A push into an empty FIFO bypasses
            // memory straight into the head.
            if (pop && (count > CW'(1))) begin
                head_q <= mem[rd_ptr_p1];
            end else if (push && ((count == '0) || pop)) begin
                head_q <= i_data;
            end
        end
    end

    assign o_free  = free_q;
    assign o_data  = head_q;
    assign o_count = count;

    // ------------------------------------------------------------------
    // Optional stall statistics
    // ------------------------------------------------------------------
`ifdef CFIFO_SINK_STATS_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (i_stats_clr) begin
            stall_cnt <= '0;
        end else if ((state == STALL) && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign o_stall_cnt = stall_cnt;
`endif

    // ------------------------------------------------------------------
    // Handshake check: while a token is being accepted the synchronized
    // request must not move; if it does, the producer toggled i_drive
    // twice without waiting for o_free.
    // ------------------------------------------------------------------
`ifndef SYNTHESIS
    a_one_token_in_flight: assert property (
        @(posedge clk) disable iff (rst)
        (state != IDLE) |-> $stable(drv_sync)
    );
`endif

endmodule

// File: tb/tb_cfifo_sync_sink.sv
module tb_cfifo_sync_sink;

  localparam int DATA_W      = 32;
  localparam int DEPTH       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int CW          = $clog2(DEPTH + 1);
  localparam int LAT         = SYNC_STAGES + 2;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic              i_drive;
  logic [DATA_W-1:0] i_data;
  logic              o_free;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic              i_ready;
  logic [CW-1:0]     o_count;
`ifdef CFIFO_SINK_STATS_EN
  logic              i_stats_clr;
  logic [15:0]       o_stall_cnt;
`endif

  always #5 clk = ~clk;

  cfifo_sync_sink #(
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_drive (i_drive),
    .i_data  (i_data),
    .o_free  (o_free),
    .o_valid (o_valid),
    .o_data  (o_data),
    .i_ready (i_ready),
    .o_count (o_count)
`ifdef CFIFO_SINK_STATS_EN
    ,
    .i_stats_clr (i_stats_clr),
    .o_stall_cnt (o_stall_cnt)
`endif
  );

  // ---------------- scoreboard state ----------------
  int                checks = 0;
  int                errors = 0;
  logic              exp_free;
  logic [DATA_W-1:0] exp_q[$];
  int                cyc;
  logic              pend;
  logic [DATA_W-1:0] pend_data;
  int                ready_at;
  int                acked;
  int                max_cnt;

  typedef struct {
    logic              rdy;
    logic              free;
    logic              valid;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] data;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] d);
    i_data  = d;
    i_drive = ~i_drive;
  endtask

  // wait for the next o_free transition, bounded
  task automatic wait_ack(output int n);
    logic target;
    target = ~exp_free;
    n = 0;
    while (o_free !== target && n < 20) begin
      tick();
      n++;
    end
    chk("ack_arrived", o_free, target);
    exp_free = target;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    i_drive = 1'b0;
    i_data  = '0;
    i_ready = 1'b0;
`ifdef CFIFO_SINK_STATS_EN
    i_stats_clr = 1'b0;
`endif
    exp_q.delete();
    exp_free = 1'b0;
    pend     = 1'b0;
    cyc      = 0;
    tick();
    tick();
    chk("rst_free", o_free, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_count", o_count, 0);
`ifdef CFIFO_SINK_STATS_EN
    chk("rst_stall_cnt", o_stall_cnt, 0);
`endif
    rst = 1'b0;
    tick();
  endtask

  // One clock of the reference model: a pending token becomes pushable
  // LAT edges after its request; it is pushed at the first such edge where
  // the buffer has room or the consumer is taking a word.
  task automatic step();
    logic pop_m;
    logic push_m;
    pop_m  = (exp_q.size() != 0) && (i_ready == 1'b1);
    push_m = pend && (cyc + 1 >= ready_at) && ((exp_q.size() < DEPTH) || pop_m);
    tick();
    cyc++;
    if (pop_m) void'(exp_q.pop_front());
    if (push_m) begin
      exp_q.push_back(pend_data);
      exp_free = ~exp_free;
      pend     = 1'b0;
      acked++;
    end
    chk("mdl_free", o_free, exp_free);
    chk("mdl_valid", o_valid, exp_q.size() != 0);
    chk("mdl_count", o_count, exp_q.size());
    if (exp_q.size() != 0) chk("mdl_data", o_data, exp_q[0]);
    if (int'(o_count) > max_cnt) max_cnt = int'(o_count);
  endtask

  task automatic run_tokens(input int n, input bit rnd, input logic [DATA_W-1:0] base);
    int sent;
    int budget;
    sent    = 0;
    budget  = 0;
    acked   = 0;
    max_cnt = 0;
    pend    = 1'b0;
    while ((acked < n || exp_q.size() != 0) && budget < n * 40 + 100) begin
      i_ready = rnd ? ($urandom_range(0, 3) == 0) : 1'b1;
      if (!pend && sent < n && (!rnd || $urandom_range(0, 2) != 0)) begin
        send(base + DATA_W'(sent));
        pend      = 1'b1;
        pend_data = base + DATA_W'(sent);
        ready_at  = cyc + LAT;
        sent++;
      end
      step();
      budget++;
    end
    chk("run_all_acked", acked, n);
    chk("run_drained", exp_q.size(), 0);
    i_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    int n;

    // ---------------- single token, table driven ----------------
    vecs[0] = '{rdy: 1'b0, free: 1'b0, valid: 1'b0, cnt: 0, data: 32'h0};
    vecs[1] = '{rdy: 1'b0, free: 1'b0, valid: 1'b0, cnt: 0, data: 32'h0};
    vecs[2] = '{rdy: 1'b0, free: 1'b0, valid: 1'b0, cnt: 0, data: 32'h0};
    vecs[3] = '{rdy: 1'b0, free: 1'b1, valid: 1'b1, cnt: 1, data: 32'hA5A5_0001};
    vecs[4] = '{rdy: 1'b0, free: 1'b1, valid: 1'b1, cnt: 1, data: 32'hA5A5_0001};
    vecs[5] = '{rdy: 1'b1, free: 1'b1, valid: 1'b0, cnt: 0, data: 32'h0};
    vecs[6] = '{rdy: 1'b0, free: 1'b1, valid: 1'b0, cnt: 0, data: 32'h0};

    do_reset();
    send(32'hA5A5_0001);
    for (int i = 0; i < 7; i++) begin
      i_ready = vecs[i].rdy;
      tick();
      chk($sformatf("single_free_c%0d", i + 1), o_free, vecs[i].free);
      chk($sformatf("single_valid_c%0d", i + 1), o_valid, vecs[i].valid);
      chk($sformatf("single_count_c%0d", i + 1), o_count, vecs[i].cnt);
      if (vecs[i].valid) chk($sformatf("single_data_c%0d", i + 1), o_data, vecs[i].data);
    end
    i_ready  = 1'b0;
    exp_free = 1'b1;

    // ---------------- streaming, consumer always ready ----------------
    run_tokens(100, 1'b0, 32'h1000_0000);
    chk("stream_max_count", max_cnt <= 1, 1);

    // ---------------- wrap-around with random ready ----------------
    run_tokens(3 * DEPTH + 1, 1'b1, 32'h2000_0000);
    run_tokens(40, 1'b1, $urandom);

    // ---------------- burst to full, stall, pop releases ----------------
    do_reset();
    for (int k = 1; k <= DEPTH; k++) begin
      send(DATA_W'(k));
      wait_ack(n);
      chk("burst_ack_latency", n, LAT);
    end
    chk("burst_full_count", o_count, DEPTH);
    chk("burst_head", o_data, 1);
    send(DATA_W'(DEPTH + 1));
    repeat (LAT) tick();
    chk("stall_free_held", o_free, exp_free);
    chk("stall_count", o_count, DEPTH);
`ifdef CFIFO_SINK_STATS_EN
    chk("stats_start", o_stall_cnt, 0);
    repeat (10) tick();
    chk("stats_10", o_stall_cnt, 10);
    i_stats_clr = 1'b1;
    tick();
    i_stats_clr = 1'b0;
    chk("stats_clr", o_stall_cnt, 0);
`else
    repeat (10) tick();
`endif
    chk("stall_free_still_held", o_free, exp_free);
    i_ready = 1'b1;
    tick();
    i_ready  = 1'b0;
    exp_free = ~exp_free;
    chk("release_free", o_free, exp_free);
    chk("release_count", o_count, DEPTH);
    for (int k = 2; k <= DEPTH + 1; k++) begin
      chk("drain_valid", o_valid, 1);
      chk("drain_data", o_data, k);
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
    end
    chk("drain_empty_valid", o_valid, 0);
    chk("drain_empty_count", o_count, 0);

    // ---------------- reset while full with a stalled token ----------------
    for (int k = 0; k < DEPTH; k++) begin
      send(32'h0B00_0000 + DATA_W'(k));
      wait_ack(n);
    end
    send(32'h0B00_00FF);
    repeat (LAT + 2) tick();
    chk("pre_rst_count", o_count, DEPTH);
    rst     = 1'b1;
    i_drive = 1'b0;
    #1;
    chk("async_rst_valid", o_valid, 0);
    chk("async_rst_count", o_count, 0);
    chk("async_rst_free", o_free, 0);
    exp_free = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    repeat (3) begin
      tick();
      chk("post_rst_no_ack", o_free, 0);
    end
    send(32'hC0DE_0001);
    wait_ack(n);
    chk("post_rst_latency", n, LAT);
    chk("post_rst_valid", o_valid, 1);
    chk("post_rst_data", o_data, 32'hC0DE_0001);
    chk("post_rst_count", o_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
